// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the FSM state encoding, the default memory depth and halt encoding,
// the instruction/address widths, and the payload type held for decode.
package if_pkg;

   localparam int unsigned IF_INSTR_W        = 16;
   localparam int unsigned IF_ADDR_W         = 16;
   localparam int unsigned IF_PERF_W         = 32;
   localparam int unsigned IF_MEM_DEPTH_DFLT = 128;

   localparam logic [IF_INSTR_W-1:0] IF_HALT_INSTR_DFLT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } if_state_e;

   // Instruction word and the address it was fetched from, as presented to decode.
   typedef struct packed {
      logic [IF_ADDR_W-1:0]  pc;
      logic [IF_INSTR_W-1:0] instr;
   } if_payload_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating performance counters for the fetch stage.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   xfer              - one transfer to decode this cycle
//   stall             - valid instruction held while decode is not ready
//   perf_fetched      - saturating count of transfers
//   perf_stalls       - saturating count of stall cycles
module fetch_perf_counter
   import if_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 xfer,
   input  logic                 stall,
   output logic [IF_PERF_W-1:0] perf_fetched,
   output logic [IF_PERF_W-1:0] perf_stalls
);

   // Both counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (xfer && (perf_fetched != '1)) begin
            perf_fetched <= perf_fetched + IF_PERF_W'(1);
         end
         if (stall && (perf_stalls != '1)) begin
            perf_stalls <= perf_stalls + IF_PERF_W'(1);
         end
      end
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to instruction memory, holds one
// fetched instruction for decode with a valid/ready handshake, and handles
// branch redirects, a halt encoding and out-of-range PC faults.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   imem_addr/imem_instruction - memory read address (the PC) and its data
//   if_instr/if_pc/if_valid   - held instruction, its address, valid flag
//   id_ready                  - decode accepts the held instruction
//   br_taken/br_target        - single-cycle redirect request
//   halted/fault              - halt and out-of-range status
//   perf_fetched/perf_stalls  - only with INSTRUCTION_FETCH_PERF_CNT_EN defined
module instruction_fetch
   import if_pkg::*;
#(
   parameter int unsigned           MEM_DEPTH  = IF_MEM_DEPTH_DFLT,
   parameter logic [IF_ADDR_W-1:0]  RESET_PC   = 16'h0000,
   parameter logic [IF_INSTR_W-1:0] HALT_INSTR = IF_HALT_INSTR_DFLT
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [IF_ADDR_W-1:0]  imem_addr,
   input  logic [IF_INSTR_W-1:0] imem_instruction,
   output logic [IF_INSTR_W-1:0] if_instr,
   output logic [IF_ADDR_W-1:0]  if_pc,
   output logic                  if_valid,
   input  logic                  id_ready,
   input  logic                  br_taken,
   input  logic [IF_ADDR_W-1:0]  br_target,
   output logic                  halted,
   output logic                  fault
`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
   ,
   output logic [IF_PERF_W-1:0]  perf_fetched,
   output logic [IF_PERF_W-1:0]  perf_stalls
`endif
);

   // One extra bit so MEM_DEPTH up to 2**16 compares correctly.
   localparam int unsigned CMP_W = IF_ADDR_W + 1;

   if_state_e            state, state_n;
   logic [IF_ADDR_W-1:0] pc, pc_n;
   if_payload_t          hold, hold_n;
   logic                 valid_n;
   logic                 halted_n;
   logic                 fault_n;
   logic                 xfer;
   logic                 pc_oob;

   assign xfer      = if_valid & id_ready;
   assign pc_oob    = {1'b0, pc} >= CMP_W'(MEM_DEPTH);
   assign imem_addr = pc;
   assign if_instr  = hold.instr;
   assign if_pc     = hold.pc;

   // Next-state and datapath update.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      hold_n  = hold;
      valid_n = if_valid;
      unique case (state)
         ST_WAIT: begin
            state_n = ST_FETCH;
         end
         ST_FETCH: begin
            if (br_taken) begin
               // Redirect wins over both fetch and stall.
               pc_n    = br_target;
               valid_n = 1'b0;
            end else if (!if_valid || xfer) begin
               if (pc_oob) begin
                  // Any held word was just consumed; nothing new is loaded.
                  state_n = ST_FAULT;
                  valid_n = 1'b0;
               end else begin
                  hold_n.instr = imem_instruction;
                  hold_n.pc    = pc;
                  valid_n      = 1'b1;
                  pc_n         = pc + IF_ADDR_W'(1);
                  if (imem_instruction == HALT_INSTR) begin
                     state_n = ST_HALT;
                  end
               end
            end
         end
         ST_HALT: begin
            if (br_taken) begin
               pc_n    = br_target;
               valid_n = 1'b0;
               state_n = ST_FETCH;
            end else if (xfer) begin
               valid_n = 1'b0;
            end
         end
         ST_FAULT: begin
            if (xfer) begin
               valid_n = 1'b0;
            end
         end
         default: begin
            state_n = ST_WAIT;
         end
      endcase
      halted_n = (state_n == ST_HALT);
      fault_n  = (state_n == ST_FAULT);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_WAIT;
         pc       <= RESET_PC;
         hold     <= '0;
         if_valid <= 1'b0;
         halted   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         hold     <= hold_n;
         if_valid <= valid_n;
         halted   <= halted_n;
         fault    <= fault_n;
      end
   end

`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
   fetch_perf_counter u_perf (
      .clk          (clk),
      .rst          (rst),
      .xfer         (xfer),
      .stall        (if_valid & ~id_ready),
      .perf_fetched (perf_fetched),
      .perf_stalls  (perf_stalls)
   );
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a directed vector table for the
// main DUT plus hand-written sequences for the fault and async-reset cases.
module tb_instruction_fetch;
   import if_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 1: default depth.
   logic        rst1, rdy1, br1;
   logic [15:0] tgt1, addr1, instr_in1, if_instr1, if_pc1;
   logic        valid1, halted1, fault1;
   logic [15:0] mem1 [256];
   assign instr_in1 = mem1[addr1[7:0]];

   // DUT 2: depth 8 for the out-of-range fault.
   logic        rst2, rdy2, br2;
   logic [15:0] tgt2, addr2, instr_in2, if_instr2, if_pc2;
   logic        valid2, halted2, fault2;
   logic [15:0] mem2 [256];
   assign instr_in2 = mem2[addr2[7:0]];

`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
   logic [31:0] fet1, stl1, fet2, stl2;
`endif

   instruction_fetch u_dut1 (
      .clk(clk), .rst(rst1), .imem_addr(addr1), .imem_instruction(instr_in1),
      .if_instr(if_instr1), .if_pc(if_pc1), .if_valid(valid1), .id_ready(rdy1),
      .br_taken(br1), .br_target(tgt1), .halted(halted1), .fault(fault1)
`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
      , .perf_fetched(fet1), .perf_stalls(stl1)
`endif
   );

   instruction_fetch #(.MEM_DEPTH(8)) u_dut2 (
      .clk(clk), .rst(rst2), .imem_addr(addr2), .imem_instruction(instr_in2),
      .if_instr(if_instr2), .if_pc(if_pc2), .if_valid(valid2), .id_ready(rdy2),
      .br_taken(br2), .br_target(tgt2), .halted(halted2), .fault(fault2)
`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
      , .perf_fetched(fet2), .perf_stalls(stl2)
`endif
   );

   typedef struct {
      logic        rst, rdy, br;
      logic [15:0] tgt;
      logic        ev;
      logic [15:0] epc, einstr, eaddr;
      logic        eh;
      logic        pf;
      logic [31:0] efet, estl;
   } vec_t;

   vec_t vq[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic rd, input logic b, input logic [15:0] t,
                      input logic ev, input logic [15:0] epc, input logic [15:0] ei,
                      input logic [15:0] ea, input logic eh, input logic pf,
                      input logic [31:0] ef, input logic [31:0] es);
      vec_t v;
      v.rst = r; v.rdy = rd; v.br = b; v.tgt = t;
      v.ev = ev; v.epc = epc; v.einstr = ei; v.eaddr = ea; v.eh = eh;
      v.pf = pf; v.efet = ef; v.estl = es;
      vq.push_back(v);
   endtask

   initial begin
      rst1 = 1'b0; rdy1 = 1'b0; br1 = 1'b0; tgt1 = 16'h0;
      rst2 = 1'b0; rdy2 = 1'b0; br2 = 1'b0; tgt2 = 16'h0;
      for (int i = 0; i < 256; i++) begin
         mem1[i] = 16'h1000 + 16'(i);
         mem2[i] = 16'h3000 + 16'(i);
      end
      for (int i = 0; i < 4; i++) mem1[i] = 16'h2403;
      mem1[4] = 16'hFFFF;

      // Sequential fetch into halt, then redirect out of halt.
      //  rst rdy br tgt      ev epc     instr     addr    h  pf fet stl
      add(0, 1, 0, 16'h0000, 0, 16'h0, 16'h0000, 16'h0, 0, 1, 0, 0);
      add(1, 1, 0, 16'h0000, 0, 16'h0, 16'h0000, 16'h0, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h0, 16'h2403, 16'h1, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h1, 16'h2403, 16'h2, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h2, 16'h2403, 16'h3, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h3, 16'h2403, 16'h4, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h4, 16'hFFFF, 16'h5, 1, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 0, 16'h4, 16'hFFFF, 16'h5, 1, 1, 5, 0);
      for (int i = 0; i < 9; i++)
         add(1, 1, 0, 16'h0000, 0, 16'h4, 16'hFFFF, 16'h5, 1, 0, 0, 0);
      add(1, 1, 1, 16'h0000, 0, 16'h4, 16'hFFFF, 16'h0, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h0, 16'h2403, 16'h1, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h1, 16'h2403, 16'h2, 0, 0, 0, 0);
      // Three-cycle stall while if_pc=2.
      add(0, 1, 0, 16'h0000, 0, 16'h0, 16'h0000, 16'h0, 0, 1, 0, 0);
      add(1, 1, 0, 16'h0000, 0, 16'h0, 16'h0000, 16'h0, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h0, 16'h2403, 16'h1, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h1, 16'h2403, 16'h2, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h2, 16'h2403, 16'h3, 0, 0, 0, 0);
      add(1, 0, 0, 16'h0000, 1, 16'h2, 16'h2403, 16'h3, 0, 0, 0, 0);
      add(1, 0, 0, 16'h0000, 1, 16'h2, 16'h2403, 16'h3, 0, 0, 0, 0);
      add(1, 0, 0, 16'h0000, 1, 16'h2, 16'h2403, 16'h3, 0, 1, 2, 3);
      add(1, 1, 0, 16'h0000, 1, 16'h3, 16'h2403, 16'h4, 0, 1, 3, 3);
      // Branch ignored in WAIT; branch to 5 while if_pc=1; branch during a stall.
      add(0, 1, 0, 16'h0000, 0, 16'h0, 16'h0000, 16'h0, 0, 0, 0, 0);
      add(1, 1, 1, 16'h0005, 0, 16'h0, 16'h0000, 16'h0, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h0, 16'h2403, 16'h1, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h1, 16'h2403, 16'h2, 0, 0, 0, 0);
      add(1, 1, 1, 16'h0005, 0, 16'h1, 16'h2403, 16'h5, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h5, 16'h1005, 16'h6, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h6, 16'h1006, 16'h7, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h7, 16'h1007, 16'h8, 0, 0, 0, 0);
      add(1, 0, 1, 16'h0002, 0, 16'h7, 16'h1007, 16'h2, 0, 0, 0, 0);
      add(1, 1, 0, 16'h0000, 1, 16'h2, 16'h2403, 16'h3, 0, 0, 0, 0);

      foreach (vq[i]) begin
         @(negedge clk);
         rst1 = vq[i].rst; rdy1 = vq[i].rdy; br1 = vq[i].br; tgt1 = vq[i].tgt;
         @(posedge clk);
         #1;
         check($sformatf("v%0d.valid", i),  32'(valid1),    32'(vq[i].ev));
         check($sformatf("v%0d.if_pc", i),  32'(if_pc1),    32'(vq[i].epc));
         check($sformatf("v%0d.instr", i),  32'(if_instr1), 32'(vq[i].einstr));
         check($sformatf("v%0d.addr", i),   32'(addr1),     32'(vq[i].eaddr));
         check($sformatf("v%0d.halted", i), 32'(halted1),   32'(vq[i].eh));
         check($sformatf("v%0d.fault", i),  32'(fault1),    32'h0);
`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
         if (vq[i].pf) begin
            check($sformatf("v%0d.fetched", i), fet1, vq[i].efet);
            check($sformatf("v%0d.stalls", i),  stl1, vq[i].estl);
         end
`endif
      end

      // Depth-8 instance: last word fetches, next attempt faults, branch ignored.
      check("d2.rst_valid", 32'(valid2), 32'h0);
      check("d2.rst_addr",  32'(addr2),  32'h0);
      check("d2.rst_fault", 32'(fault2), 32'h0);
      @(negedge clk);
      rst2 = 1'b1; rdy2 = 1'b1;
      @(posedge clk); #1;
      check("d2.wait_valid", 32'(valid2), 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         check($sformatf("d2.k%0d.valid", k), 32'(valid2),    32'h1);
         check($sformatf("d2.k%0d.if_pc", k), 32'(if_pc2),    32'(k));
         check($sformatf("d2.k%0d.instr", k), 32'(if_instr2), 32'(16'h3000 + 16'(k)));
         check($sformatf("d2.k%0d.fault", k), 32'(fault2),    32'h0);
      end
      @(posedge clk); #1;
      check("d2.flt_fault", 32'(fault2), 32'h1);
      check("d2.flt_valid", 32'(valid2), 32'h0);
      check("d2.flt_addr",  32'(addr2),  32'h8);
      @(negedge clk);
      br2 = 1'b1; tgt2 = 16'h0000;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("d2.br%0d.addr", k),  32'(addr2),  32'h8);
         check($sformatf("d2.br%0d.fault", k), 32'(fault2), 32'h1);
         check($sformatf("d2.br%0d.valid", k), 32'(valid2), 32'h0);
      end
`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
      check("d2.fetched", fet2, 32'd8);
`endif
      @(negedge clk);
      br2 = 1'b0;

      // Asynchronous reset mid-stall while if_pc=2.
      @(negedge clk);
      rst1 = 1'b0; rdy1 = 1'b1; br1 = 1'b0;
      @(negedge clk);
      rst1 = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rdy1 = 1'b0;
      @(posedge clk); #1;
      check("ar.pre_valid", 32'(valid1), 32'h1);
      check("ar.pre_pc",    32'(if_pc1), 32'h2);
      #2;
      rst1 = 1'b0;
      #1;
      check("ar.valid", 32'(valid1),    32'h0);
      check("ar.if_pc", 32'(if_pc1),    32'h0);
      check("ar.instr", 32'(if_instr1), 32'h0);
      check("ar.addr",  32'(addr1),     32'h0);
`ifdef INSTRUCTION_FETCH_PERF_CNT_EN
      check("ar.stalls", stl1, 32'h0);
`endif
      @(negedge clk);
      rst1 = 1'b1; rdy1 = 1'b1;
      @(posedge clk); #1;
      check("ar.wait_valid", 32'(valid1), 32'h0);
      check("ar.wait_addr",  32'(addr1),  32'h0);
      @(posedge clk); #1;
      check("ar.first_valid", 32'(valid1), 32'h1);
      check("ar.first_pc",    32'(if_pc1), 32'h0);
      check("ar.first_addr",  32'(addr1),  32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
